// File: rtl/tsu_queue_arbiter.sv
// Round-robin drain of the RX/TX tsu_queue read sides onto one valid/ready port; RD_LAT+3 cycles per entry.
// Optional TSU_ARB_STATS_EN adds per-source transfer counters with synchronous clear.
module tsu_queue_arbiter #(
  parameter int RD_LAT = 1,
  parameter int STAT_W = 8
) (
  input  logic              q_rd_clk,
  input  logic              q_rst_n,
  input  logic [STAT_W-1:0] rx_rd_stat,
  input  logic [55:0]       rx_rd_data,
  output logic              rx_rd_en,
  input  logic [STAT_W-1:0] tx_rd_stat,
  input  logic [55:0]       tx_rd_data,
  output logic              tx_rd_en,
  input  logic [1:0]        src_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [55:0]       out_data,
  output logic              out_src,
  output logic              busy
`ifdef TSU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       rx_cnt,
  output logic [15:0]       tx_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t      state_q;
  logic        grant_q, grant_d;
  logic        last_q;
  logic [1:0]  lat_q;
  logic        rx_en_q, tx_en_q;
  logic        valid_q;
  logic [55:0] data_q;
  logic        src_q;
  logic        req_rx, req_tx;

  // Grant value 0 = RX, 1 = TX; on contention serve the side that did not win last time.
  always_comb begin
    req_rx  = src_en[0] & (|rx_rd_stat);
    req_tx  = src_en[1] & (|tx_rd_stat);
    grant_d = (req_rx & req_tx) ? ~last_q : req_tx;
  end

  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      lat_q   <= 2'd0;
      rx_en_q <= 1'b0;
      tx_en_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 56'd0;
      src_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rx | req_tx) begin
            grant_q <= grant_d;
            rx_en_q <= ~grant_d;
            tx_en_q <= grant_d;
            state_q <= READ;
          end
        end
        READ: begin
          rx_en_q <= 1'b0;
          tx_en_q <= 1'b0;
          lat_q   <= LAT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == 2'd0) begin
            data_q  <= grant_q ? tx_rd_data : rx_rd_data;
            src_q   <= grant_q;
            valid_q <= 1'b1;
            last_q  <= grant_q;
            state_q <= HOLD;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_rd_en  = rx_en_q;
  assign tx_rd_en  = tx_en_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign busy      = (state_q != IDLE);

`ifdef TSU_ARB_STATS_EN
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic        xfer;

  assign xfer = valid_q & out_ready;

  // Clear takes priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      rx_cnt_q <= 16'd0;
      tx_cnt_q <= 16'd0;
    end else if (stat_clr) begin
      rx_cnt_q <= 16'd0;
      tx_cnt_q <= 16'd0;
    end else if (xfer) begin
      if (!src_q && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (src_q && tx_cnt_q != 16'hFFFF)  tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;
`endif

endmodule

// File: tb/tb_tsu_queue_arbiter.sv
// Bench for tsu_queue_arbiter: behavioural tsu_queue read-side models feed the DUT, expected entries go to a scoreboard.
module tb_tsu_queue_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_rd_stat, tx_rd_stat;
  logic [55:0] rx_rd_data, tx_rd_data;
  logic        rx_rd_en, tx_rd_en;
  logic [1:0]  src_en = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [55:0] out_data;
  logic        out_src;
  logic        busy;
`ifdef TSU_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] rx_cnt, tx_cnt;
`endif

  always #5 clk = ~clk;

  tsu_queue_arbiter #(.RD_LAT(RD_LAT), .STAT_W(8)) dut (
    .q_rd_clk   (clk),
    .q_rst_n    (rst_n),
    .rx_rd_stat (rx_rd_stat),
    .rx_rd_data (rx_rd_data),
    .rx_rd_en   (rx_rd_en),
    .tx_rd_stat (tx_rd_stat),
    .tx_rd_data (tx_rd_data),
    .tx_rd_en   (tx_rd_en),
    .src_en     (src_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .busy       (busy)
`ifdef TSU_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .rx_cnt     (rx_cnt),
    .tx_cnt     (tx_cnt)
`endif
  );

  int n_err = 0;
  int n_chk = 0;
  logic [56:0] sb[$];

  logic [55:0] rx_mem[32];
  logic [55:0] tx_mem[32];
  int rx_loaded = 0, tx_loaded = 0;
  int rx_ptr = 0, tx_ptr = 0;
  logic [55:0] rx_pipe[RD_LAT];
  logic [55:0] tx_pipe[RD_LAT];
  int rx_pulses = 0, tx_pulses = 0, xfers = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [55:0] rx_val(input int i);
    return {8'hA0, 48'(i)};
  endfunction

  function automatic logic [55:0] tx_val(input int i);
    return {8'hB0, 48'(i)};
  endfunction

  always_comb begin
    rx_rd_stat = 8'(rx_loaded - rx_ptr);
    tx_rd_stat = 8'(tx_loaded - tx_ptr);
    rx_rd_data = rx_pipe[RD_LAT-1];
    tx_rd_data = tx_pipe[RD_LAT-1];
  end

  // Queue read-side model: data appears RD_LAT cycles after the strobe; reset empties the queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ptr <= rx_loaded;
      tx_ptr <= tx_loaded;
      for (int i = 0; i < RD_LAT; i++) begin
        rx_pipe[i] <= 56'd0;
        tx_pipe[i] <= 56'd0;
      end
    end else begin
      if (rx_rd_en) begin
        rx_pipe[0] <= rx_mem[rx_ptr % 32];
        rx_ptr     <= rx_ptr + 1;
      end
      if (tx_rd_en) begin
        tx_pipe[0] <= tx_mem[tx_ptr % 32];
        tx_ptr     <= tx_ptr + 1;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        rx_pipe[i] <= rx_pipe[i-1];
        tx_pipe[i] <= tx_pipe[i-1];
      end
    end
  end

  initial begin
    logic [56:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rd_excl", 64'(rx_rd_en & tx_rd_en), 64'd0);
        chk("rd_vs_valid", 64'((rx_rd_en | tx_rd_en) & out_valid), 64'd0);
        chk("rx_uflow", 64'(rx_rd_en && rx_rd_stat == 8'd0), 64'd0);
        chk("tx_uflow", 64'(tx_rd_en && tx_rd_stat == 8'd0), 64'd0);
        if (rx_rd_en) rx_pulses++;
        if (tx_rd_en) tx_pulses++;
        if (out_valid && out_ready) begin
          xfers++;
          if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
          end else begin
            exp = sb.pop_front();
            chk("out_entry", 64'({out_src, out_data}), 64'(exp));
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_rx(input int n);
    for (int k = 0; k < n; k++) begin
      rx_mem[rx_loaded % 32] = rx_val(rx_loaded);
      rx_loaded++;
    end
  endtask

  task automatic load_tx(input int n);
    for (int k = 0; k < n; k++) begin
      tx_mem[tx_loaded % 32] = tx_val(tx_loaded);
      tx_loaded++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    sb.delete();
    tick(3);
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!out_valid && c < 30) begin
      tick();
      c++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    sb.delete();
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int rb, tb0, p0, x0;

    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rx_en", 64'(rx_rd_en), 64'd0);
    chk("rst_tx_en", 64'(tx_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // RX only, three entries in order
    src_en = 2'b11;
    out_ready = 1'b1;
    rb = rx_loaded;
    p0 = rx_pulses;
    x0 = tx_pulses;
    load_rx(3);
    for (int k = 0; k < 3; k++) sb.push_back({1'b0, rx_val(rb + k)});
    drain("t1_drain", 60);
    chk("t1_rx_pulses", 64'(rx_pulses - p0), 64'd3);
    chk("t1_tx_pulses", 64'(tx_pulses - x0), 64'd0);

    // Both sources after reset: alternate starting with RX
    do_reset();
    rb = rx_loaded;
    tb0 = tx_loaded;
    load_rx(2);
    load_tx(2);
    for (int k = 0; k < 2; k++) begin
      sb.push_back({1'b0, rx_val(rb + k)});
      sb.push_back({1'b1, tx_val(tb0 + k)});
    end
    drain("t2_drain", 80);

    // Consumer backpressure: entry held, no new reads
    out_ready = 1'b0;
    rb = rx_loaded;
    load_rx(1);
    sb.push_back({1'b0, rx_val(rb)});
    wait_valid("t3_valid");
    load_rx(1);
    sb.push_back({1'b0, rx_val(rb + 1)});
    p0 = rx_pulses + tx_pulses;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data", 64'(out_data), 64'(rx_val(rb)));
    end
    chk("t3_no_rd", 64'(rx_pulses + tx_pulses - p0), 64'd0);
    x0 = xfers;
    out_ready = 1'b1;
    tick();
    chk("t3_one_xfer", 64'(xfers - x0), 64'd1);
    chk("t3_valid_drop", 64'(out_valid), 64'd0);
    drain("t3_drain", 40);

    // RX disabled: only TX drained
    src_en = 2'b10;
    rb = rx_loaded;
    tb0 = tx_loaded;
    p0 = rx_pulses;
    x0 = tx_pulses;
    load_rx(4);
    load_tx(4);
    for (int k = 0; k < 4; k++) sb.push_back({1'b1, tx_val(tb0 + k)});
    drain("t4_drain", 80);
    chk("t4_rx_pulses", 64'(rx_pulses - p0), 64'd0);
    chk("t4_tx_pulses", 64'(tx_pulses - x0), 64'd4);
    chk("t4_rx_left", 64'(rx_rd_stat), 64'd4);

    // Reset during WAIT drops the in-flight entry; first grant afterwards is RX
    out_ready = 1'b0;
    src_en = 2'b11;
    begin
      int c = 0;
      while (!rx_rd_en && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("t5_rd_seen", 64'(rx_rd_en), 64'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_rx_en", 64'(rx_rd_en), 64'd0);
    chk("t5_tx_en", 64'(tx_rd_en), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
`ifdef TSU_ARB_STATS_EN
    chk("t5_rx_cnt", 64'(rx_cnt), 64'd0);
    chk("t5_tx_cnt", 64'(tx_cnt), 64'd0);
`endif
    tick(2);
    rst_n = 1'b1;
    sb.delete();
    tick();
    rb = rx_loaded;
    tb0 = tx_loaded;
    load_rx(1);
    load_tx(1);
    sb.push_back({1'b0, rx_val(rb)});
    sb.push_back({1'b1, tx_val(tb0)});
    out_ready = 1'b1;
    drain("t5_drain", 40);

`ifdef TSU_ARB_STATS_EN
    // Counters: clear, count 5 RX / 3 TX, then clear wins over a same-cycle transfer
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t6_clr_rx", 64'(rx_cnt), 64'd0);
    chk("t6_clr_tx", 64'(tx_cnt), 64'd0);
    rb = rx_loaded;
    tb0 = tx_loaded;
    load_rx(5);
    load_tx(3);
    for (int k = 0; k < 3; k++) begin
      sb.push_back({1'b0, rx_val(rb + k)});
      sb.push_back({1'b1, tx_val(tb0 + k)});
    end
    sb.push_back({1'b0, rx_val(rb + 3)});
    sb.push_back({1'b0, rx_val(rb + 4)});
    drain("t6_drain", 120);
    chk("t6_rx_cnt", 64'(rx_cnt), 64'd5);
    chk("t6_tx_cnt", 64'(tx_cnt), 64'd3);
    out_ready = 1'b0;
    rb = rx_loaded;
    load_rx(1);
    sb.push_back({1'b0, rx_val(rb)});
    wait_valid("t6_valid");
    out_ready = 1'b1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t6_coll_rx", 64'(rx_cnt), 64'd0);
    chk("t6_coll_tx", 64'(tx_cnt), 64'd0);
    drain("t6_drain2", 20);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
